// File: rtl/dac_patgen_pkg.sv
// dac_patgen_pkg: mode encoding and full-scale helpers shared by the DAC pattern generator
package dac_patgen_pkg;
   localparam int MODE_W = 2;
   typedef enum logic [MODE_W-1:0] {MODE_OFF, MODE_PULSE, MODE_RAMP, MODE_BURST} mode_e;
   function automatic logic [63:0] fs_pos(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction
   function automatic logic [63:0] fs_neg(input int w);
      return 64'd1 << (w - 1);
   endfunction
endpackage

// File: rtl/dac_patgen_ramp.sv
// dac_patgen_ramp: registered SPB-lane ramp; ports clk/rst_n, load_i (restart at 0, take step_i), adv_i (next beat), step_i, lanes_o
module dac_patgen_ramp #(
   parameter int SAMPLE_W = 16,
   parameter int SPB      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_i,
   input  logic                    adv_i,
   input  logic [SAMPLE_W-1:0]     step_i,
   output logic [SPB*SAMPLE_W-1:0] lanes_o
);
   logic [SAMPLE_W-1:0]     step_q, step_d, phase_d;
   logic [SPB*SAMPLE_W-1:0] lanes_q, lanes_d;
   // lane 0 of lanes_q is the current phase; the next phase follows on from the last lane
   always_comb begin
      step_d  = load_i ? step_i : step_q;
      phase_d = load_i ? '0 : lanes_q[(SPB-1)*SAMPLE_W +: SAMPLE_W] + step_q;
      lanes_d = lanes_q;
      if (load_i || adv_i)
         for (int k = 0; k < SPB; k++)
            lanes_d[k*SAMPLE_W +: SAMPLE_W] = phase_d + SAMPLE_W'(k) * step_d;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         step_q  <= '0;
         lanes_q <= '0;
      end else begin
         step_q  <= step_d;
         lanes_q <= lanes_d;
      end
   assign lanes_o = lanes_q;
endmodule

// File: rtl/dac_pattern_gen.sv
// dac_pattern_gen: AXI4-Stream DAC test pattern source (OFF/PULSE/RAMP/BURST); ports dac_axi_clk, RESETn, mode_i, step_i, burst_len_i, axis_tready_i, dac_axis_tdata, dac_axis_tvalid, beat_cnt_o; DAC_PATGEN_BEAT_CNT_EN enables beat_cnt_o
module dac_pattern_gen
   import dac_patgen_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int SPB      = 8,
   parameter int NUM_CH   = 8,
   parameter int PERIOD_W = 4,
   parameter int BURST_W  = 8
) (
   input  logic                    dac_axi_clk,
   input  logic                    RESETn,
   input  logic [MODE_W-1:0]       mode_i,
   input  logic [SAMPLE_W-1:0]     step_i,
   input  logic [BURST_W-1:0]      burst_len_i,
   input  logic [NUM_CH-1:0]       axis_tready_i,
   output logic [SPB*SAMPLE_W-1:0] dac_axis_tdata,
   output logic                    dac_axis_tvalid,
   output logic [31:0]             beat_cnt_o
);
   localparam logic [SAMPLE_W-1:0] MAX_POS = SAMPLE_W'(fs_pos(SAMPLE_W));
   localparam logic [SAMPLE_W-1:0] MAX_NEG = SAMPLE_W'(fs_neg(SAMPLE_W));
   localparam logic [PERIOD_W-1:0] PC_MAX  = '1;
   localparam logic [PERIOD_W-1:0] PC_HALF = PC_MAX >> 1;
   mode_e                   mode_q, mode_d, mode_s;
   logic [PERIOD_W-1:0]     pc_q, pc_d;
   logic [BURST_W-1:0]      len_q, len_d, bc_q, bc_d;
   logic                    boff_q, boff_d, tvalid_q, tvalid_d, sel_q, sel_d;
   logic [SAMPLE_W-1:0]     pat_q, pat_d;
   logic                    ready, acc, adv, chg, bwrap, ramp_adv;
   logic [SPB*SAMPLE_W-1:0] ramp_lanes;
   // every registered value describes the beat currently presented; nothing moves while stalled
   always_comb begin
      ready    = &axis_tready_i;
      acc      = tvalid_q & ready;
      adv      = ~tvalid_q | ready;
      mode_s   = mode_e'(mode_i);
      chg      = adv && (mode_s != mode_q);
      mode_d   = adv ? mode_s : mode_q;
      len_d    = chg ? ((burst_len_i == '0) ? BURST_W'(1) : burst_len_i) : len_q;
      pc_d     = chg ? '0 : (adv && mode_q == MODE_PULSE) ? pc_q + PERIOD_W'(1) : pc_q;
      ramp_adv = acc && (mode_q == MODE_RAMP || mode_q == MODE_BURST);
      bwrap    = bc_q == len_q - BURST_W'(1);
      bc_d     = bc_q;
      boff_d   = boff_q;
      if (chg) begin
         bc_d   = '0;
         boff_d = 1'b0;
      end else if (adv && mode_q == MODE_BURST && (boff_q || acc)) begin
         bc_d   = bwrap ? '0 : bc_q + BURST_W'(1);
         boff_d = bwrap ? ~boff_q : boff_q;
      end
      sel_d    = sel_q;
      pat_d    = pat_q;
      tvalid_d = tvalid_q;
      if (adv) begin
         sel_d    = (mode_d == MODE_RAMP) || (mode_d == MODE_BURST && !boff_d);
         pat_d    = (mode_d != MODE_PULSE) ? '0 : (pc_d == PC_MAX) ? MAX_POS : (pc_d == PC_HALF) ? MAX_NEG : '0;
         tvalid_d = sel_d || (mode_d == MODE_PULSE && (pc_d == PC_MAX || pc_d == PC_HALF));
      end
   end
   always_ff @(posedge dac_axi_clk or negedge RESETn)
      if (!RESETn) begin
         mode_q   <= MODE_OFF;
         pc_q     <= '0;
         len_q    <= '0;
         bc_q     <= '0;
         boff_q   <= 1'b0;
         sel_q    <= 1'b0;
         pat_q    <= '0;
         tvalid_q <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         pc_q     <= pc_d;
         len_q    <= len_d;
         bc_q     <= bc_d;
         boff_q   <= boff_d;
         sel_q    <= sel_d;
         pat_q    <= pat_d;
         tvalid_q <= tvalid_d;
      end
   dac_patgen_ramp #(.SAMPLE_W(SAMPLE_W), .SPB(SPB)) u_ramp (
      .clk     (dac_axi_clk),
      .rst_n   (RESETn),
      .load_i  (chg),
      .adv_i   (ramp_adv),
      .step_i  (step_i),
      .lanes_o (ramp_lanes)
   );
   assign dac_axis_tdata  = sel_q ? ramp_lanes : {SPB{pat_q}};
   assign dac_axis_tvalid = tvalid_q;
`ifdef DAC_PATGEN_BEAT_CNT_EN
   logic [31:0] bcnt_q, bcnt_d;
   always_comb bcnt_d = chg ? '0 : acc ? bcnt_q + 32'd1 : bcnt_q;
   always_ff @(posedge dac_axi_clk or negedge RESETn)
      if (!RESETn) bcnt_q <= '0;
      else bcnt_q <= bcnt_d;
   assign beat_cnt_o = bcnt_q;
`else
   assign beat_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dac_pattern_gen.sv
// tb_dac_pattern_gen: scoreboard bench for dac_pattern_gen with directed vectors
module tb_dac_pattern_gen;
   localparam int TW = 128;
`ifdef DAC_PATGEN_BEAT_CNT_EN
   localparam int BC_EN = 1;
`else
   localparam int BC_EN = 0;
`endif
   typedef struct {
      logic [TW-1:0] data;
      int            cyc;
   } exp_t;
   logic          clk = 1'b0, rst_n = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [15:0]   step = '0;
   logic [7:0]    blen = '0;
   logic [7:0]    tready = 8'hFF;
   logic [TW-1:0] tdata;
   logic          tvalid;
   logic [31:0]   bcnt;
   exp_t          q[$];
   int            nvec = 0, nerr = 0, cyc = 0, n0;
   logic [TW-1:0] prev_data;
   logic          prev_stall = 1'b0;
   localparam logic [TW-1:0] NEG8 = {8{16'h8000}};
   localparam logic [TW-1:0] POS8 = {8{16'h7FFF}};

   dac_pattern_gen dut (
      .dac_axi_clk     (clk),
      .RESETn          (rst_n),
      .mode_i          (mode),
      .step_i          (step),
      .burst_len_i     (blen),
      .axis_tready_i   (tready),
      .dac_axis_tdata  (tdata),
      .dac_axis_tvalid (tvalid),
      .beat_cnt_o      (bcnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [TW-1:0] rb(input logic [15:0] base, input logic [15:0] st);
      logic [TW-1:0] r;
      for (int k = 0; k < 8; k++) r[k*16 +: 16] = base + 16'(k) * st;
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int c, input logic [TW-1:0] d);
      q.push_back('{data: d, cyc: c});
   endtask

   task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic go(input logic [1:0] m, input logic [15:0] st, input logic [7:0] bl, output int c);
      mode = m;
      step = st;
      blen = bl;
      c    = cyc;
   endtask

   task automatic stop_after(input int n);
      tick(n);
      mode = 2'd0;
      tick(2);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            nvec++;
            if (!tvalid || tdata !== prev_data) begin
               nerr++;
               $display("FAIL hold@%0d: got v=%b %h expected v=1 %h", cyc, tvalid, tdata, prev_data);
            end
         end
         if (!tvalid) begin
            nvec++;
            if (tdata !== '0) begin
               nerr++;
               $display("FAIL idle_zero@%0d: got %h expected 0", cyc, tdata);
            end
         end
         while (q.size() > 0 && q[0].cyc < cyc) begin
            nvec++;
            nerr++;
            e = q.pop_front();
            $display("FAIL missing_beat: got none at cycle %0d expected %h", e.cyc, e.data);
         end
         if (tvalid && (&tready)) begin
            nvec++;
            if (q.size() == 0) begin
               nerr++;
               $display("FAIL unexpected_beat@%0d: got %h expected none", cyc, tdata);
            end else begin
               e = q.pop_front();
               if (e.cyc != cyc || e.data !== tdata) begin
                  nerr++;
                  $display("FAIL beat: got %h at %0d expected %h at %0d", tdata, cyc, e.data, e.cyc);
               end
            end
         end
         prev_stall = tvalid && !(&tready);
         prev_data  = tdata;
      end
   end

   initial begin
      tick(3);
      chk("reset_tdata", tdata, '0);
      chk("reset_tvalid", TW'(tvalid), '0);
      chk("reset_bcnt", TW'(bcnt), '0);
      rst_n = 1'b1;
      tick(2);
      // PULSE: max negative at counter 7, max positive at 15
      go(2'd1, 16'd0, 8'd0, n0);
      push(n0 + 8, NEG8);
      push(n0 + 16, POS8);
      push(n0 + 24, NEG8);
      push(n0 + 32, POS8);
      stop_after(32);
      // RAMP step 1
      go(2'd2, 16'd1, 8'd0, n0);
      push(n0 + 1, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
      push(n0 + 2, 128'h000F_000E_000D_000C_000B_000A_0009_0008);
      push(n0 + 3, 128'h0017_0016_0015_0014_0013_0012_0011_0010);
      stop_after(3);
      // RAMP step 0x1000 wraps without saturation
      go(2'd2, 16'h1000, 8'd0, n0);
      push(n0 + 1, 128'h7000_6000_5000_4000_3000_2000_1000_0000);
      push(n0 + 2, 128'hF000_E000_D000_C000_B000_A000_9000_8000);
      push(n0 + 3, 128'h7000_6000_5000_4000_3000_2000_1000_0000);
      stop_after(3);
      // RAMP with a 5-cycle stall and a mode change presented while stalled
      go(2'd2, 16'd1, 8'd0, n0);
      push(n0 + 1, rb(16'd0, 16'd1));
      push(n0 + 7, rb(16'd8, 16'd1));
      push(n0 + 8, rb(16'd16, 16'd1));
      tick(2);
      tready = 8'hF7;
      tick(1);
      mode = 2'd3;
      tick(4);
      tready = 8'hFF;
      mode   = 2'd2;
      stop_after(1);
      // BURST len 4: 4 beats on, 4 cycles off, phase continues
      go(2'd3, 16'd1, 8'd4, n0);
      for (int i = 0; i < 4; i++) push(n0 + 1 + i, rb(16'(8 * i), 16'd1));
      for (int i = 0; i < 4; i++) push(n0 + 9 + i, rb(16'(32 + 8 * i), 16'd1));
      stop_after(12);
      // BURST len 0 behaves as len 1
      go(2'd3, 16'd1, 8'd0, n0);
      push(n0 + 1, rb(16'd0, 16'd1));
      push(n0 + 3, rb(16'd8, 16'd1));
      push(n0 + 5, rb(16'd16, 16'd1));
      stop_after(5);
      // RAMP -> PULSE -> RAMP restarts at 0 and clears the beat counter
      go(2'd2, 16'd1, 8'd0, n0);
      push(n0 + 1, rb(16'd0, 16'd1));
      push(n0 + 2, rb(16'd8, 16'd1));
      push(n0 + 4, rb(16'd0, 16'd1));
      push(n0 + 5, rb(16'd8, 16'd1));
      tick(2);
      chk("bcnt_ramp", TW'(bcnt), TW'(BC_EN));
      mode = 2'd1;
      tick(1);
      mode = 2'd2;
      tick(1);
      chk("bcnt_cleared", TW'(bcnt), '0);
      tick(1);
      chk("bcnt_restart", TW'(bcnt), TW'(BC_EN));
      mode = 2'd0;
      tick(2);
      // asynchronous reset mid-burst, then restart from phase 0
      go(2'd3, 16'd1, 8'd4, n0);
      push(n0 + 1, rb(16'd0, 16'd1));
      tick(2);
      rst_n = 1'b0;
      #1;
      chk("async_rst_tdata", tdata, '0);
      chk("async_rst_tvalid", TW'(tvalid), '0);
      chk("async_rst_bcnt", TW'(bcnt), '0);
      tick(2);
      rst_n = 1'b1;
      n0 = cyc;
      #1;
      chk("post_rst_off", TW'(tvalid), '0);
      push(n0 + 1, rb(16'd0, 16'd1));
      push(n0 + 2, rb(16'd8, 16'd1));
      stop_after(2);
      tick(3);
      chk("queue_drained", TW'(q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
